// File: rtl/jk_cmd_arbiter.sv
// Round-robin arbiter that sequences hold/clear/set/toggle commands from two
// requesters onto a shared bank of JK flip-flops, one command per three cycles.
module jk_cmd_arbiter #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            REQ0,
  input  logic [1:0]      OP0,
  input  logic [IDXW-1:0] IDX0,
  input  logic            REQ1,
  input  logic [1:0]      OP1,
  input  logic [IDXW-1:0] IDX1,
  output logic            ACK0,
  output logic            ACK1,
  output logic [N-1:0]    EN,
  output logic [N-1:0]    J,
  output logic [N-1:0]    K,
  output logic [N-1:0]    Q,
  output logic            BUSY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic           sel_reg, sel_next;
  logic           last_reg, last_next;
  logic [N-1:0]   q_reg, q_next;
  logic [N-1:0]   en_reg, en_next;
  logic [N-1:0]   j_reg, j_next;
  logic [N-1:0]   k_reg, k_next;
  logic           ack0_reg, ack0_next;
  logic           ack1_reg, ack1_next;
  logic           busy_reg, busy_next;

  logic            win;
  logic [1:0]      op_win;
  logic [IDXW-1:0] idx_win;
  logic [N-1:0]    onehot_win;

  // Ties go to the requester that was not served last.
  assign win     = (REQ0 && REQ1) ? ~last_reg : REQ1;
  assign op_win  = win ? OP1 : OP0;
  assign idx_win = win ? IDX1 : IDX0;

  // Indices at or beyond N decode to an all-zero enable.
  for (genvar gi = 0; gi < N; gi++) begin : g_dec
    assign onehot_win[gi] = (idx_win == IDXW'(gi));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= IDLE;
      sel_reg   <= 1'b0;
      last_reg  <= 1'b1;
      q_reg     <= '0;
      en_reg    <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
      ack0_reg  <= 1'b0;
      ack1_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      last_reg  <= last_next;
      q_reg     <= q_next;
      en_reg    <= en_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
      ack0_reg  <= ack0_next;
      ack1_reg  <= ack1_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    last_next  = last_reg;
    q_next     = q_reg;
    en_next    = '0;
    j_next     = '0;
    k_next     = '0;
    ack0_next  = 1'b0;
    ack1_next  = 1'b0;
    busy_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (REQ0 || REQ1) begin
          // The registered strobes double as the latched opcode and index.
          sel_next   = win;
          en_next    = onehot_win;
          j_next     = op_win[1] ? onehot_win : '0;
          k_next     = op_win[0] ? onehot_win : '0;
          busy_next  = 1'b1;
          state_next = APPLY;
        end
      end
      APPLY: begin
        q_next     = (q_reg & ~en_reg) |
                     (en_reg & ((j_reg & ~q_reg) | (~k_reg & q_reg)));
        ack0_next  = ~sel_reg;
        ack1_next  = sel_reg;
        busy_next  = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        last_next  = sel_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ACK0 = ack0_reg;
  assign ACK1 = ack1_reg;
  assign EN   = en_reg;
  assign J    = j_reg;
  assign K    = k_reg;
  assign Q    = q_reg;
  assign BUSY = busy_reg;

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// Directed bench for jk_cmd_arbiter: single ops, ties, fairness, hold,
// out-of-range index (N=3 instance) and asynchronous reset.
module tb_jk_cmd_arbiter;

  logic       CLK;
  logic       RESET;
  logic       REQ0, REQ1;
  logic [1:0] OP0, OP1;
  logic [1:0] IDX0, IDX1;
  logic       ACK0, ACK1, BUSY;
  logic [3:0] EN, J, K, Q;

  logic       REQ0_3, REQ1_3;
  logic [1:0] OP0_3, OP1_3;
  logic [1:0] IDX0_3, IDX1_3;
  logic       ACK0_3, ACK1_3, BUSY_3;
  logic [2:0] EN_3, J_3, K_3, Q_3;

  int n_asserts = 0;
  int n_fail    = 0;

  jk_cmd_arbiter #(.N(4), .IDXW(2)) u_dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .OP0(OP0), .IDX0(IDX0),
    .REQ1(REQ1), .OP1(OP1), .IDX1(IDX1),
    .ACK0(ACK0), .ACK1(ACK1), .EN(EN), .J(J), .K(K), .Q(Q), .BUSY(BUSY)
  );

  jk_cmd_arbiter #(.N(3), .IDXW(2)) u_dut3 (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0_3), .OP0(OP0_3), .IDX0(IDX0_3),
    .REQ1(REQ1_3), .OP1(OP1_3), .IDX1(IDX1_3),
    .ACK0(ACK0_3), .ACK1(ACK1_3), .EN(EN_3), .J(J_3), .K(K_3), .Q(Q_3), .BUSY(BUSY_3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Issues one command on the N=4 instance from IDLE and checks all three cycles.
  task automatic do_cmd(input string tag, input bit r, input logic [1:0] op, input logic [1:0] idx,
                        input logic [3:0] exp_en, input logic [3:0] exp_j,
                        input logic [3:0] exp_k, input logic [3:0] exp_q);
    if (r) begin
      REQ1 = 1'b1; OP1 = op; IDX1 = idx;
    end else begin
      REQ0 = 1'b1; OP0 = op; IDX0 = idx;
    end
    step();
    check({tag, ".apply.en"},   32'(EN),   32'(exp_en));
    check({tag, ".apply.j"},    32'(J),    32'(exp_j));
    check({tag, ".apply.k"},    32'(K),    32'(exp_k));
    check({tag, ".apply.busy"}, 32'(BUSY), 32'd1);
    check({tag, ".apply.ack"},  32'({ACK1, ACK0}), 32'd0);
    step();
    check({tag, ".done.q"},    32'(Q),  32'(exp_q));
    check({tag, ".done.ack"},  32'({ACK1, ACK0}), r ? 32'd2 : 32'd1);
    check({tag, ".done.en"},   32'(EN), 32'd0);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    step();
    check({tag, ".idle.ack"},  32'({ACK1, ACK0}), 32'd0);
    check({tag, ".idle.busy"}, 32'(BUSY), 32'd0);
    $display("txn %s: req%0d op=%0d idx=%0d -> Q=%b", tag, r, op, idx, Q);
  endtask

  initial begin
    REQ0 = 0; REQ1 = 0; OP0 = 0; OP1 = 0; IDX0 = 0; IDX1 = 0;
    REQ0_3 = 0; REQ1_3 = 0; OP0_3 = 0; OP1_3 = 0; IDX0_3 = 0; IDX1_3 = 0;
    RESET = 1'b0;
    #1;
    check("rst.q",    32'(Q),    32'd0);
    check("rst.en",   32'(EN),   32'd0);
    check("rst.ack",  32'({ACK1, ACK0}), 32'd0);
    check("rst.busy", 32'(BUSY), 32'd0);
    step();
    step();
    #3 RESET = 1'b1;
    step();
    check("post_rst.busy", 32'(BUSY), 32'd0);

    do_cmd("set2",    1'b0, 2'b10, 2'd2, 4'b0100, 4'b0100, 4'b0000, 4'b0100);
    do_cmd("toggle2", 1'b0, 2'b11, 2'd2, 4'b0100, 4'b0100, 4'b0100, 4'b0000);
    do_cmd("toggle0", 1'b0, 2'b11, 2'd0, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
    do_cmd("clear0",  1'b0, 2'b01, 2'd0, 4'b0001, 4'b0000, 4'b0001, 4'b0000);

    // Tie from reset: requester 0 first, then requester 1.
    RESET = 1'b0;
    #2 RESET = 1'b1;
    REQ0 = 1; OP0 = 2'b10; IDX0 = 2'd1;
    REQ1 = 1; OP1 = 2'b10; IDX1 = 2'd3;
    step();
    check("tie.a.en",   32'(EN),   32'b0010);
    check("tie.a.busy", 32'(BUSY), 32'd1);
    step();
    check("tie.a.ack", 32'({ACK1, ACK0}), 32'd1);
    check("tie.a.q",   32'(Q), 32'b0010);
    check("tie.a.busy2", 32'(BUSY), 32'd1);
    REQ0 = 0;
    step();
    check("tie.idle.busy", 32'(BUSY), 32'd0);
    check("tie.idle.ack",  32'({ACK1, ACK0}), 32'd0);
    step();
    check("tie.b.en",   32'(EN),   32'b1000);
    check("tie.b.j",    32'(J),    32'b1000);
    check("tie.b.busy", 32'(BUSY), 32'd1);
    step();
    check("tie.b.ack", 32'({ACK1, ACK0}), 32'd2);
    check("tie.b.q",   32'(Q), 32'b1010);
    REQ1 = 0;
    step();
    check("tie.end.busy", 32'(BUSY), 32'd0);
    $display("txn tie: req0 set1 then req1 set3 -> Q=%b", Q);

    // Asynchronous reset with Q=1010, checked before any clock edge.
    #2 RESET = 1'b0;
    #1;
    check("arst.q",    32'(Q),    32'd0);
    check("arst.en",   32'(EN),   32'd0);
    check("arst.ack",  32'({ACK1, ACK0}), 32'd0);
    check("arst.busy", 32'(BUSY), 32'd0);
    #1 RESET = 1'b1;
    $display("txn async reset -> Q=%b", Q);

    // Fairness: both requesters toggle bit 0 continuously.
    REQ0 = 1; OP0 = 2'b11; IDX0 = 2'd0;
    REQ1 = 1; OP1 = 2'b11; IDX1 = 2'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fair.busy", 32'(BUSY), 32'd1);
      step();
      check("fair.ack", 32'({ACK1, ACK0}), (i % 2 == 1) ? 32'd2 : 32'd1);
      check("fair.q0",  32'(Q[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
      step();
      check("fair.idle", 32'(BUSY), 32'd0);
      if (i == 3) begin
        REQ0 = 0;
        REQ1 = 0;
      end
      $display("txn fair %0d: ack1=%b ack0 served, Q=%b", i, (i % 2 == 1), Q);
    end
    step();
    check("fair.stop", 32'(BUSY), 32'd0);

    do_cmd("set1",  1'b0, 2'b10, 2'd1, 4'b0010, 4'b0010, 4'b0000, 4'b0010);
    do_cmd("hold1", 1'b0, 2'b00, 2'd1, 4'b0010, 4'b0000, 4'b0000, 4'b0010);

    // N=3 instance: in-range SET idx2 then out-of-range SET idx3.
    REQ0_3 = 1; OP0_3 = 2'b10; IDX0_3 = 2'd2;
    step();
    check("n3.set2.en", 32'(EN_3), 32'b100);
    step();
    check("n3.set2.q",   32'(Q_3), 32'b100);
    check("n3.set2.ack", 32'({ACK1_3, ACK0_3}), 32'd1);
    REQ0_3 = 0;
    step();
    $display("txn n3 set2 -> Q=%b", Q_3);
    REQ0_3 = 1; OP0_3 = 2'b10; IDX0_3 = 2'd3;
    step();
    check("n3.oor.en",   32'(EN_3), 32'b000);
    check("n3.oor.j",    32'(J_3),  32'b000);
    check("n3.oor.busy", 32'(BUSY_3), 32'd1);
    step();
    check("n3.oor.q",   32'(Q_3), 32'b100);
    check("n3.oor.ack", 32'({ACK1_3, ACK0_3}), 32'd1);
    REQ0_3 = 0;
    step();
    check("n3.oor.idle", 32'(BUSY_3), 32'd0);
    $display("txn n3 set3 (out of range) -> Q=%b", Q_3);

    // Reset during APPLY of SET idx3 loses the command.
    REQ0 = 1; OP0 = 2'b10; IDX0 = 2'd3;
    step();
    check("midrst.apply.en", 32'(EN), 32'b1000);
    #2 RESET = 1'b0;
    #1;
    check("midrst.q",    32'(Q),    32'd0);
    check("midrst.en",   32'(EN),   32'd0);
    check("midrst.busy", 32'(BUSY), 32'd0);
    REQ0 = 0;
    step();
    check("midrst.noack", 32'({ACK1, ACK0}), 32'd0);
    #3 RESET = 1'b1;
    step();
    check("midrst.after.ack",  32'({ACK1, ACK0}), 32'd0);
    check("midrst.after.busy", 32'(BUSY), 32'd0);
    $display("txn reset mid-op -> Q=%b", Q);
    do_cmd("tog3_r1", 1'b1, 2'b11, 2'd3, 4'b1000, 4'b1000, 4'b1000, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_cmd_arbiter.md
Name: jk_cmd_arbiter

Overview:
- Controller and arbiter that shares one N-bit bank of JK flip-flops between two requesters.
- Each requester issues a command to one bit: hold, clear, set or toggle.
- The block grants requesters round-robin, sequences the EN/J/K strobes for one cycle, updates the bank and acknowledges the winner.
- It sits between the lab's JK flip-flop datapath and the stimulus/control logic that previously drove EN/J/K by hand.

Parameters:
- N, 4, number of JK bits in the bank.
- IDXW, 2, width of the bit-index fields; must satisfy 2^IDXW >= N.

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset; RESET=0 forces reset state immediately.
- REQ0  in  1  requester 0 command request, level, held until ACK0.
- OP0  in  2  requester 0 opcode: 00 HOLD, 01 CLEAR, 10 SET, 11 TOGGLE.
- IDX0  in  IDXW  requester 0 target bit.
- REQ1  in  1  requester 1 request.
- OP1  in  2  requester 1 opcode.
- IDX1  in  IDXW  requester 1 target bit.
- ACK0  out  1  one-cycle completion pulse for requester 0.
- ACK1  out  1  one-cycle completion pulse for requester 1.
- EN  out  N  per-bit enable strobe, one-hot or zero.
- J  out  N  per-bit J drive, valid when the matching EN bit is 1.
- K  out  N  per-bit K drive, valid when the matching EN bit is 1.
- Q  out  N  JK bank state.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RESET=0, asynchronous):
  - State=IDLE; Q=0; EN=J=K=0; ACK0=ACK1=0; BUSY=0.
  - Round-robin pointer LAST=1, so requester 0 wins the first tie.
- State machine: IDLE -> APPLY -> DONE -> IDLE, all outputs registered.
- IDLE:
  - At a rising edge, if REQ0|REQ1: choose the winner, latch its OP/IDX into SEL/OPL/IDXL and go to APPLY.
  - Otherwise stay in IDLE.
  - Arbitration: only one requester high -> that requester wins. Both high -> winner = ~LAST.
- APPLY (one cycle):
  - EN = one-hot(IDXL). J/K at that bit from OPL: HOLD 0/0, CLEAR 0/1, SET 1/0, TOGGLE 1/1. All other bits have EN=J=K=0.
  - At the edge ending APPLY, Q[IDXL] updates per JK rules: HOLD keeps, CLEAR->0, SET->1, TOGGLE->~Q. Other bits are unchanged. Then go to DONE.
- DONE (one cycle):
  - EN=J=K=0; ACK[SEL]=1; LAST<=SEL; next state IDLE.
  - REQ inputs are ignored in DONE.
- Latency:
  - REQ sampled at edge t.
  - EN/J/K are visible during cycle t..t+1.
  - Q changes at edge t+1.
  - ACK is high between edge t+1 and edge t+2.
  - IDLE is reached at edge t+2.
  - Maximum throughput is one command per 3 cycles.
- Requester contract:
  - Hold REQ/OP/IDX stable until ACK is seen.
  - Deassert REQ before the edge ending the first IDLE cycle after ACK. A REQ still high there is treated as a new command.
  - OP/IDX of a non-granted requester may change freely.
- Out-of-range IDX (IDXL >= N):
  - Sequence proceeds normally with EN=0 in APPLY.
  - Q is unchanged.
  - ACK is still issued.
- Simultaneous requests: the loser keeps REQ high. It is granted at the next IDLE arbitration, because LAST now points to the winner. No starvation: alternation is guaranteed with both requesters continuously requesting.
- Reset mid-operation (APPLY or DONE):
  - Immediate return to the reset state. Q is cleared, no ACK is issued and the pending command is lost.
  - After RESET returns to 1, the next rising edge samples normally.

Test Plan:
- Reset: RESET=0 with Q previously 4'b1010 -> Q=0000, EN=0, ACK0=ACK1=0, BUSY=0 immediately, without waiting for a clock edge.
- Single ops, requester 0, N=4 from Q=0000:
  - SET idx2 -> EN=0100, J=0100, K=0000 during APPLY; Q=0100; ACK0 pulses one cycle, 2 edges after grant.
  - TOGGLE idx2 -> Q=0000.
  - TOGGLE idx0 -> Q=0001.
  - CLEAR idx0 -> Q=0000.
- Tie from reset: REQ0 (SET idx1) and REQ1 (SET idx3) both high at the same edge:
  - Requester 0 is served first: ACK0, Q=0010.
  - Then requester 1 is served: ACK1, Q=1010.
  - Total 6 cycles, BUSY stays high except the single IDLE cycle between.
- Fairness: both requesters hold TOGGLE idx0 continuously with a re-request after each ACK -> ACKs alternate 0,1,0,1 and Q[0] toggles on every command.
- HOLD and out-of-range: HOLD idx1 with Q=0010 -> Q unchanged and ACK issued. With N=3, IDX=3 SET -> EN=000, Q unchanged, ACK issued.
- Reset mid-op: RESET driven low during APPLY of SET idx3 -> Q=0000, no ACK. After release, a fresh REQ1 TOGGLE idx3 -> Q=1000 and ACK1.
